shift_rows_pipe: RTL and testbench

- Pipelined, parametrised ShiftRows stage for the AES/Rijndael datapath.
- Supports block widths of Nb = 4, 6 or 8 columns, and forward or inverse permutation selected per block.
- Uses a valid/ready handshake, so it can sit between SubBytes and MixColumns (encrypt) or their inverses (decrypt) under backpressure.
- Replaces the fixed 128-bit, forward-only, en/done ShiftRows.

---
 rtl/aes_pkg.sv | 29 ++
 rtl/shift_rows_perm.sv | 34 +++
 rtl/shift_rows_pipe.sv | 95 +++++++++
 tb/tb_shift_rows_pipe.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES ShiftRows constants, legal block widths, row offsets and byte indexing
package aes_pkg;

    localparam int ROWS          = 4;
    localparam int WORD_SIZE_DEF = 8;
    localparam int NB_MAX        = 8;

    typedef logic [WORD_SIZE_DEF-1:0]                 state_byte_t;
    typedef state_byte_t [0:ROWS-1][0:NB_MAX-1]       state_t;

    function automatic bit nb_legal(input int nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    // Rijndael row offsets; the 256-bit block uses a wider spread for rows 2 and 3
    function automatic int row_shift(input int nb, input int r);
        case (r)
            1:       return 1;
            2:       return (nb == 8) ? 3 : 2;
            3:       return (nb == 8) ? 4 : 3;
            default: return 0;
        endcase
    endfunction

    function automatic int idx(input int r, input int c);
        return 4 * c + r;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// rtl/shift_rows_perm.sv - combinational ShiftRows byte permutation; SHIFT_ROWS_INV_EN adds the inverse direction
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NB        = 4
) (
    input  logic [0:WORD_SIZE*ROWS*NB-1] state,
    input  logic                         inv,
    output logic [0:WORD_SIZE*ROWS*NB-1] result
);

`ifndef SHIFT_ROWS_INV_EN
    logic unused_inv;
    assign unused_inv = inv;
`endif

    // Pure wiring: every output byte picks one source byte chosen at elaboration
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int FWD_SRC = idx(r, (c + row_shift(NB, r)) % NB);
`ifdef SHIFT_ROWS_INV_EN
            localparam int INV_SRC = idx(r, (c - row_shift(NB, r) + NB) % NB);
            assign result[idx(r, c)*WORD_SIZE +: WORD_SIZE] =
                inv ? state[INV_SRC*WORD_SIZE +: WORD_SIZE]
                    : state[FWD_SRC*WORD_SIZE +: WORD_SIZE];
`else
            assign result[idx(r, c)*WORD_SIZE +: WORD_SIZE] =
                state[FWD_SRC*WORD_SIZE +: WORD_SIZE];
`endif
        end
    end

endmodule

// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - two-stage valid/ready ShiftRows pipeline; SHIFT_ROWS_INV_EN enables per-block inverse
module shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter int NB        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_inv,
    input  logic [0:WORD_SIZE*4*NB-1]    in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [0:WORD_SIZE*4*NB-1]    out_data
);

    localparam int W = WORD_SIZE * ROWS * NB;

    if (!nb_legal(NB)) begin : g_nb_check
        $error("shift_rows_pipe: NB must be 4, 6 or 8");
    end

    logic           a_valid;
    logic           b_valid;
    logic           b_ready;
    logic           a_load;
    logic           b_load;
    logic           perm_inv;
    logic [0:W-1]   a_data;
    logic [0:W-1]   b_data;
    logic [0:W-1]   perm_data;

    assign b_ready  = !b_valid || out_ready;
    assign in_ready = !a_valid || b_ready;
    assign a_load   = in_valid && in_ready;
    assign b_load   = a_valid && b_ready;

    // Flush only clears the valid flags; data registers keep whatever they hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else if (flush) begin
            a_valid <= 1'b0;
            b_valid <= 1'b0;
        end else begin
            if (in_ready) a_valid <= in_valid;
            if (b_ready)  b_valid <= a_valid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_data <= '0;
            b_data <= '0;
        end else begin
            if (a_load) a_data <= in_data;
            if (b_load) b_data <= perm_data;
        end
    end

`ifdef SHIFT_ROWS_INV_EN
    logic a_inv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_inv <= 1'b0;
        end else if (a_load) begin
            a_inv <= in_inv;
        end
    end

    assign perm_inv = a_inv;
`else
    logic unused_in_inv;
    assign unused_in_inv = in_inv;
    assign perm_inv      = 1'b0;
`endif

    shift_rows_perm #(
        .WORD_SIZE (WORD_SIZE),
        .NB        (NB)
    ) u_perm (
        .state  (a_data),
        .inv    (perm_inv),
        .result (perm_data)
    );

    assign out_valid = b_valid;
    assign out_data  = b_data;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - directed-vector bench for shift_rows_pipe at NB=4 and NB=8
module tb_shift_rows_pipe;

    localparam logic [127:0] SEQ16    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FWD16    = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] INV16    = 128'h000d0a0704010e0b0805020f0c090603;
    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [255:0] SEQ32    =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] FWD32    =
        256'h00050e1304091217080d161b0c111a1f10151e0314190207181d060b1c010a0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         out_ready;
    logic         in_valid4, in_inv4, in_ready4, out_valid4;
    logic [0:127] in_data4, out_data4;
    logic         in_valid8, in_inv8, in_ready8, out_valid8;
    logic [0:255] in_data8, out_data8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_rows_pipe #(.WORD_SIZE(8), .NB(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_inv(in_inv4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4)
    );

    shift_rows_pipe #(.WORD_SIZE(8), .NB(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_inv(in_inv8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Byte-broadcast XOR commutes with any byte permutation, so expected outputs follow by hand
    function automatic logic [127:0] blk_in(input int i);
        logic [7:0] b;
        b = 8'(i * 17);
        return SEQ16 ^ {16{b}};
    endfunction

    function automatic logic [127:0] blk_out(input int i);
        logic [7:0] b;
        b = 8'(i * 17);
        return FWD16 ^ {16{b}};
    endfunction

    // Called at posedge+1 with both pipelines empty; returns at posedge+1 after the result is consumed
    task automatic xfer(input string tag, input bit wide, input logic [255:0] d,
                        input logic inv, input logic [255:0] exp, output logic [255:0] res);
        out_ready = 1'b1;
        if (wide) begin
            in_data8 = d; in_inv8 = inv; in_valid8 = 1'b1;
        end else begin
            in_data4 = d[127:0]; in_inv4 = inv; in_valid4 = 1'b1;
        end
        @(negedge clk);
        check({tag, "_in_ready"}, wide ? in_ready8 : in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0; in_valid8 = 1'b0; in_inv4 = 1'b0; in_inv8 = 1'b0;
        @(negedge clk);
        check({tag, "_lat0"}, wide ? out_valid8 : out_valid4, 0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_valid"}, wide ? out_valid8 : out_valid4, 1);
        res = wide ? out_data8 : {128'b0, out_data4};
        check({tag, "_data"}, res, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [255:0] res;
        logic [127:0] held;
        bit           rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int           sent, got, occ;
        bit           stalled, emit, acc;

        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; in_inv4 = 1'b0; in_data4 = '0;
        in_valid8 = 1'b0; in_inv8 = 1'b0; in_data8 = '0;
        #2;
        check("rst_out_valid", out_valid4, 0);
        check("rst_out_data", out_data4, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready4, 1);
        @(posedge clk); #1;

        xfer("fwd4", 1'b0, SEQ16, 1'b0, FWD16, res);
        xfer("fips", 1'b0, FIPS_IN, 1'b0, FIPS_OUT, res);
`ifdef SHIFT_ROWS_INV_EN
        xfer("fips_inv", 1'b0, res, 1'b1, FIPS_IN, res);
        xfer("inv4", 1'b0, SEQ16, 1'b1, INV16, res);
        xfer("fwd8", 1'b1, SEQ32, 1'b0, FWD32, res);
        xfer("inv8", 1'b1, res, 1'b1, SEQ32, res);
`else
        xfer("inv_ignored", 1'b0, SEQ16, 1'b1, FWD16, res);
        xfer("fwd8", 1'b1, SEQ32, 1'b0, FWD32, res);
`endif

        // Backpressure: 8 blocks offered back to back, out_ready cycling 1,0,0,1
        sent = 0; got = 0; occ = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            out_ready = rdy_pat[cyc % 4];
            in_valid4 = (sent < 8);
            in_data4  = blk_in(sent);
            @(negedge clk);
            check("bp_in_ready", in_ready4, !(occ == 2 && !out_ready));
            if (stalled) check("bp_stable", out_data4, held);
            emit = out_valid4 && out_ready;
            acc  = in_valid4 && in_ready4;
            if (emit) begin
                check("bp_order", out_data4, blk_out(got));
                got++;
            end
            stalled = out_valid4 && !out_ready;
            held    = out_data4;
            if (acc) sent++;
            occ = occ + int'(acc) - int'(emit);
            @(posedge clk); #1;
        end
        in_valid4 = 1'b0;
        check("bp_count", got, 8);
        @(negedge clk);
        check("bp_drained", out_valid4, 0);
        @(posedge clk); #1;

        // Asynchronous reset with two blocks in flight
        out_ready = 1'b0;
        in_valid4 = 1'b1; in_data4 = blk_in(1);
        @(posedge clk); #1;
        in_data4 = blk_in(2);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        #1;
        check("arst_pre_valid", out_valid4, 1);
        #1 rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid4, 0);
        check("arst_out_data", out_data4, 0);
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", in_ready4, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_stale", out_valid4, 0);
        end
        @(posedge clk); #1;

        // Flush discards a block offered in the same cycle
        out_ready = 1'b1; flush = 1'b1;
        in_valid4 = 1'b1; in_data4 = SEQ16;
        @(negedge clk);
        check("flush_in_ready", in_ready4, 1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid4 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("flush_dropped", out_valid4, 0);
        end
        @(posedge clk); #1;
        xfer("post_flush", 1'b0, FIPS_IN, 1'b0, FIPS_OUT, res);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
